// File: rtl/subblock_sched_pkg.sv
// Shared types and defaults for the sub-block scheduler.
// FSM state encoding, default sizing and counter width.
package subblock_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int N_REQ_DEF   = 5;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/subblock_rr_pick.sv
// Combinational round-robin picker: first set req bit above last_id.
// Ports: req, last_id in; valid, index out.
module subblock_rr_pick #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_id,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Scan from the farthest offset down so the
  // nearest set bit after last_id is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last_id) + k) % N]) begin
        valid = 1'b1;
        index = IW'((int'(last_id) + k) % N);
      end
    end
  end

endmodule

// File: rtl/subblock_scheduler.sv
// Round-robin grant scheduler for child sub-blocks with timeout release.
// Ports: clk, rst_n, enable_i, req_i, done_i -> gnt_o, gnt_id_o, busy_o, timeout_o, err_id_o.
module subblock_scheduler
  import subblock_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    gnt_id_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [IW-1:0]    err_id_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             rdy;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             busy_nxt, to_nxt;
  logic [IW-1:0]    last_id, last_nxt;
  logic [IW-1:0]    err_nxt;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

  subblock_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req_i),
    .last_id (last_id),
    .valid   (pick_valid),
    .index   (pick_idx)
  );

  assign gnt_id_o = last_id;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt_o;
    busy_nxt  = busy_o;
    to_nxt    = 1'b0;
    last_nxt  = last_id;
    err_nxt   = err_id_o;
    unique case (state)
      IDLE: begin
        // rdy holds off grants for one edge after reset release
        if (rdy && enable_i && pick_valid) begin
          state_nxt = BUSY;
          gnt_nxt   = N_REQ'(1) << pick_idx;
          busy_nxt  = 1'b1;
          last_nxt  = pick_idx;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (done_i[last_id]) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          to_nxt    = 1'b1;
          err_nxt   = last_id;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b0;
      cnt       <= '0;
      gnt_o     <= '0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
      last_id   <= IW'(N_REQ - 1);
      err_id_o  <= '0;
    end else begin
      state     <= state_nxt;
      rdy       <= 1'b1;
      cnt       <= cnt_nxt;
      gnt_o     <= gnt_nxt;
      busy_o    <= busy_nxt;
      timeout_o <= to_nxt;
      last_id   <= last_nxt;
      err_id_o  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_subblock_scheduler.sv
// Scoreboard bench for subblock_scheduler (N_REQ=5, TIMEOUT=8).
// Stimulus queues expected grants/timeouts; a negedge monitor checks them.
module tb_subblock_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_i;
  logic [4:0] req_i;
  logic [4:0] done_i;
  logic [4:0] gnt_o;
  logic [2:0] gnt_id_o;
  logic       busy_o;
  logic       timeout_o;
  logic [2:0] err_id_o;

  always #5 clk = ~clk;

  subblock_scheduler #(
    .N_REQ   (5),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_i  (enable_i),
    .req_i     (req_i),
    .done_i    (done_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o),
    .err_id_o  (err_id_o)
  );

  typedef struct {
    bit         is_to;
    logic [4:0] gnt;
    logic [2:0] id;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm,
                              logic [15:0] act,
                              logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, want);
    end
  endfunction

  function automatic void push_g(logic [4:0] g,
                                 logic [2:0] id);
    exp_t e;
    e.is_to = 1'b0;
    e.gnt   = g;
    e.id    = id;
    q.push_back(e);
  endfunction

  function automatic void push_t(logic [2:0] id);
    exp_t e;
    e.is_to = 1'b1;
    e.gnt   = '0;
    e.id    = id;
    q.push_back(e);
  endfunction

  // Monitor: new grant (rising gnt) or timeout pulse
  logic [4:0] prev_gnt = '0;
  exp_t me;
  always @(negedge clk) begin
    if (gnt_o != 5'd0 && prev_gnt == 5'd0) begin
      if (q.size() == 0 || q[0].is_to) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_grant: got %b want none",
                 gnt_o);
      end else begin
        me = q.pop_front();
        chk("sb_gnt", 16'(gnt_o), 16'(me.gnt));
        chk("sb_gnt_id", 16'(gnt_id_o), 16'(me.id));
        chk("sb_onehot", 16'($countones(gnt_o)), 16'd1);
      end
    end
    if (timeout_o === 1'b1) begin
      if (q.size() == 0 || !q[0].is_to) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_timeout: got pulse want none");
      end else begin
        me = q.pop_front();
        chk("sb_err_id", 16'(err_id_o), 16'(me.id));
      end
    end
    prev_gnt = gnt_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt_o == 5'd0 && n < 30);
    if (gnt_o == 5'd0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_gnt: got no grant want grant");
    end
  endtask

  int n;
  int ids[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst_n    = 1'b0;
    enable_i = 1'b1;
    req_i    = '0;
    done_i   = '0;
    tick();
    tick();
    chk("rst_gnt", 16'(gnt_o), 16'd0);
    chk("rst_busy", 16'(busy_o), 16'd0);
    chk("rst_to", 16'(timeout_o), 16'd0);
    chk("rst_err", 16'(err_id_o), 16'd0);
    chk("rst_id", 16'(gnt_id_o), 16'd4);

    // single requester, done on cycle 4
    rst_n = 1'b1;
    req_i = 5'b00001;
    push_g(5'b00001, 3'd0);
    tick();
    chk("sync_rel", 16'(gnt_o), 16'd0);
    tick();
    chk("t1_gnt", 16'(gnt_o), 16'b00001);
    chk("t1_busy", 16'(busy_o), 16'd1);
    tick();
    tick();
    tick();
    done_i = 5'b00001;
    req_i  = '0;
    tick();
    done_i = '0;
    chk("t1_gap_gnt", 16'(gnt_o), 16'd0);
    chk("t1_gap_busy", 16'(busy_o), 16'd0);
    tick();
    chk("t1_idle", 16'(busy_o), 16'd0);

    // all request, round robin from reset
    rst_n = 1'b0;
    tick();
    req_i = 5'b11111;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      push_g(5'd1 << ids[i], 3'(ids[i]));
    for (int i = 0; i < 6; i++) begin
      wait_gnt(n);
      chk("rr_spacing", 16'(n), 16'd2);
      tick();
      tick();
      done_i = 5'd1 << ids[i];
      if (i == 5) req_i = '0;
      tick();
      done_i = '0;
    end

    // timeout: grantee drops req, never done
    req_i = 5'b00100;
    push_g(5'b00100, 3'd2);
    push_t(3'd2);
    wait_gnt(n);
    req_i = '0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("to_hold", 16'(gnt_o), 16'b00100);
    end
    tick();
    chk("to_gnt", 16'(gnt_o), 16'd0);
    chk("to_busy", 16'(busy_o), 16'd0);
    chk("to_pulse", 16'(timeout_o), 16'd1);
    chk("to_err", 16'(err_id_o), 16'd2);
    tick();
    chk("to_one", 16'(timeout_o), 16'd0);

    // done on timeout cycle wins; foreign done ignored
    req_i = 5'b00100;
    push_g(5'b00100, 3'd2);
    wait_gnt(n);
    req_i = '0;
    tick();
    tick();
    done_i = 5'b01000;
    tick();
    done_i = '0;
    chk("foreign_done", 16'(busy_o), 16'd1);
    tick();
    tick();
    tick();
    tick();
    done_i = 5'b00100;
    tick();
    done_i = '0;
    chk("dw_gnt", 16'(gnt_o), 16'd0);
    chk("dw_to", 16'(timeout_o), 16'd0);
    chk("dw_err", 16'(err_id_o), 16'd2);

    // reset mid-busy drops grant asynchronously
    req_i = 5'b01000;
    push_g(5'b01000, 3'd3);
    wait_gnt(n);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 16'(gnt_o), 16'd0);
    chk("arst_busy", 16'(busy_o), 16'd0);
    tick();
    chk("arst_id", 16'(gnt_id_o), 16'd4);
    chk("arst_to", 16'(timeout_o), 16'd0);
    req_i = 5'b11000;
    rst_n = 1'b1;
    push_g(5'b01000, 3'd3);
    wait_gnt(n);
    chk("arst_lat", 16'(n), 16'd2);
    done_i = 5'b01000;
    req_i  = '0;
    tick();
    done_i = '0;
    tick();

    // enable gating
    enable_i = 1'b0;
    req_i    = 5'b00010;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("en_block", 16'(gnt_o), 16'd0);
    end
    enable_i = 1'b1;
    push_g(5'b00010, 3'd1);
    tick();
    chk("en_gnt", 16'(gnt_o), 16'b00010);
    chk("en_id", 16'(gnt_id_o), 16'd1);
    enable_i = 1'b0;
    tick();
    tick();
    chk("en_busy_hold", 16'(gnt_o), 16'b00010);
    chk("en_busy", 16'(busy_o), 16'd1);
    done_i = 5'b00010;
    req_i  = '0;
    tick();
    done_i   = '0;
    enable_i = 1'b1;
    chk("en_release", 16'(gnt_o), 16'd0);
    tick();
    tick();
    chk("q_empty", 16'(q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/subblock_scheduler.md
SUBBLOCK_SCHEDULER -- requirements
Module: subblock_scheduler

Interface
REQ-001 Parameter N_REQ, default 5, number of requesting child sub-blocks (sb9_0..sb9_4), legal range 2..8.
REQ-002 Parameter TIMEOUT, default 255, maximum BUSY cycles before forced release, legal range 1..65535.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable_i  input  1  scheduler enable; low blocks new grants only.
REQ-006 req_i  input  N_REQ  per-child request, level-sensitive.
REQ-007 done_i  input  N_REQ  per-child completion strobe, one cycle.
REQ-008 gnt_o  output  N_REQ  one-hot grant; at most one bit set.
REQ-009 gnt_id_o  output  $clog2(N_REQ)  index of current/last grantee.
REQ-010 busy_o  output  1  high while a grant is held.
REQ-011 timeout_o  output  1  one-cycle pulse on forced release.
REQ-012 err_id_o  output  $clog2(N_REQ)  index of last timed-out grantee, held until next timeout.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, GAP; reset state IDLE.
REQ-014 IDLE: if enable_i and any req_i bit set, next cycle SHALL enter BUSY with gnt_o one-hot on the winner (1-cycle req-to-grant latency).
REQ-015 Winner SHALL be the first set req_i bit searching upward from last_id+1, wrapping N_REQ-1 -> 0 (round-robin).
REQ-016 last_id SHALL update to the winner index when the grant is issued; gnt_id_o SHALL equal last_id.
REQ-017 BUSY: gnt_o and busy_o SHALL hold constant; req_i changes SHALL be ignored, including deassertion by the grantee.
REQ-018 BUSY: cycle counter (16 bit, cleared on grant) SHALL increment each cycle.
REQ-019 BUSY with done_i[last_id]=1 SHALL enter GAP next cycle, gnt_o=0, busy_o=0.
REQ-020 done_i bits of non-granted children SHALL be ignored in all states.
REQ-021 BUSY with counter==TIMEOUT-1 and no done SHALL enter GAP, pulse timeout_o for that one cycle, load err_id_o=last_id.
REQ-022 done and timeout in the same cycle: done SHALL win; no timeout_o pulse.
REQ-023 GAP SHALL last exactly one cycle and then go to IDLE; minimum two idle cycles between grants (grant-to-grant with continuous req: BUSY len + 2).
REQ-024 enable_i low in BUSY SHALL NOT affect the current grant; low in IDLE SHALL keep gnt_o=0.
REQ-025 No request and enable high: SHALL stay IDLE, outputs unchanged.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, gnt_o=0, busy_o=0, timeout_o=0, counter=0, err_id_o=0.
REQ-027 Reset SHALL set last_id=N_REQ-1 so index 0 wins first.
REQ-028 Reset mid-BUSY SHALL drop the grant immediately; no timeout_o pulse; first post-reset winner follows REQ-027.
REQ-029 Reset deassertion SHALL be used synchronously; first grant no earlier than second rising edge after release.

Structure
REQ-030 Package subblock_sched_pkg SHALL hold the FSM state enum, default N_REQ, default TIMEOUT, counter width constant.
REQ-031 Round-robin pick SHALL be a combinational sub-module subblock_rr_pick (inputs req vector, last_id; outputs valid, index).
REQ-032 All outputs SHALL be registered.

Verification
REQ-033 Reset, req_i=5'b00001 -> cycle 1 gnt_o=00001, gnt_id_o=0; done_i[0] at cycle 4 -> cycle 5 gnt_o=0, GAP, cycle 6 IDLE.
REQ-034 req_i=5'b11111 held, each grantee asserts done 2 cycles after grant -> grant order 0,1,2,3,4,0; never two gnt bits set.
REQ-035 TIMEOUT=8, req_i=5'b00100, no done -> gnt_o=00100 for 8 cycles, timeout_o pulse on 8th, err_id_o=2, then GAP.
REQ-036 TIMEOUT=8, done_i[2] on the timeout cycle -> no timeout_o, err_id_o unchanged; done_i[3] while 2 granted -> ignored.
REQ-037 rst_n low during BUSY with id=3 -> gnt_o=0 asynchronously; after release req_i=5'b11000 -> winner 3.
REQ-038 enable_i=0 with req_i=5'b00010 for 10 cycles -> gnt_o=0; enable_i=1 -> gnt_o=00010 next cycle.
